// File: rtl/spart_rx_if.sv
// Bus-side bundle of the SPART receiver: serial line, divisor, read acknowledge and
// the received byte with its status flags.
interface spart_rx_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
);
    logic              rxd;
    logic [DIV_W-1:0]  divisor_buffer;
    logic              rx_ack;
    logic [DATA_W-1:0] rx_data;
    logic              rda;
    logic              framing_err;
    logic              overrun;

    modport master (
        output rxd, divisor_buffer, rx_ack,
        input  rx_data, rda, framing_err, overrun
    );

    modport slave (
        input  rxd, divisor_buffer, rx_ack,
        output rx_data, rda, framing_err, overrun
    );
endinterface

// File: rtl/spart_rx.sv
// SPART serial receive engine: synchronises rxd, finds the start edge and samples 8N1
// frames at mid-bit, reporting each byte with sticky framing/overrun status.
module spart_rx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    spart_rx_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               rxd_s, rxd_prev_q;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rda_q, rda_d;
    logic               fe_q, fe_d;
    logic               ovr_q, ovr_d;
    logic               tick, rda_set, fe_set;

    assign rxd_s = sync_q[SYNC_STAGES-1];
    assign tick  = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q != '0) ? cnt_q - DIV_W'(1) : cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rda_set   = 1'b0;
        fe_set    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Edge (not level) trigger so a held-low break line never restarts a frame.
                if (!rxd_s && rxd_prev_q) begin
                    state_d = StStart;
                    cnt_d   = bus.divisor_buffer >> 1;
                end
            end
            StStart: begin
                if (tick) begin
                    if (!rxd_s) begin
                        state_d   = StData;
                        cnt_d     = bus.divisor_buffer;
                        bit_idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {rxd_s, shift_q[DATA_W-1:1]};
                    cnt_d   = bus.divisor_buffer;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    state_d   = StIdle;
                    rx_data_d = shift_q;
                    rda_set   = rxd_s;
                    fe_set    = !rxd_s;
                end
            end
            default: state_d = StIdle;
        endcase

        // A set event beats a same-cycle acknowledge; an acknowledged read is never an overrun.
        rda_d = rda_set | (rda_q & ~bus.rx_ack);
        fe_d  = fe_set | (fe_q & ~bus.rx_ack);
        ovr_d = (rda_set & rda_q & ~bus.rx_ack) | (ovr_q & ~bus.rx_ack);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '1;
            rxd_prev_q <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rda_q      <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.rxd};
            rxd_prev_q <= rxd_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rda_q      <= rda_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rda         = rda_q;
    assign bus.framing_err = fe_q;
    assign bus.overrun     = ovr_q;
endmodule
